// File: rtl/gate_check_pkg.sv
// Shared types and sizing helpers for the gate truth-table checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold the value HOLD: ceil(log2(hold+1)), at least 1.
  function automatic int clog2_hold(input int hold);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < hold + 1) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gate_truth_checker.sv
// Sweeps all 2**N_IN vectors into a gate, HOLD cycles each, and compares against EXPECT;
// done lands 2**N_IN*HOLD cycles after start, no backpressure (dut_out must settle within HOLD).
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                 N_IN   = 2,
  parameter int                 HOLD   = 4,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int              TW       = clog2_hold(HOLD);
  localparam int              NV       = 2**N_IN;
  localparam logic [TW-1:0]   T_LOAD   = TW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(NV);

  state_t        state;
  logic [TW-1:0] timer;
  logic          mismatch;

  assign mismatch = (dut_out != EXPECT[vec_out]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      vec_out    <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            timer      <= T_LOAD;
            vec_out    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        ST_RUN: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            // Last cycle of the hold window: sample, then advance or finish.
            if (mismatch) begin
              if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= vec_out;
              end
            end
            timer <= T_LOAD;
            if (vec_out == VEC_LAST) begin
              vec_out <= '0;
              state   <= ST_DONE;
            end else begin
              vec_out <= vec_out + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboarded bench: randomized gate truth tables against a truth-table reference model.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int errs;
    int fv;
    int fvec;
    int e0;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: defaults (2-input OR expected, HOLD=4)
  logic       start_a = 1'b0;
  logic [1:0] vec_a;
  logic       out_a, busy_a, done_a, pass_a, fv_a;
  logic [2:0] err_a;
  logic [1:0] fvec_a;
  logic [3:0] tbl_a = 4'b1110;
  int         e0a = 0;
  assign out_a = tbl_a[vec_a];

  gate_truth_checker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  // Instance B: 3-input AND expected, HOLD=1
  logic       start_b = 1'b0;
  logic [2:0] vec_b;
  logic       out_b, busy_b, done_b, pass_b, fv_b;
  logic [3:0] err_b;
  logic [2:0] fvec_b;
  logic [7:0] tbl_b = 8'h80;
  int         e0b = 0;
  assign out_b = tbl_b[vec_b];

  gate_truth_checker #(.N_IN(3), .HOLD(1), .EXPECT(8'b1000_0000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: errors are the vectors where the gate's table disagrees with the expected one.
  function automatic exp_t model(input int tbl, input int expv, input int nv);
    exp_t e;
    e.errs = 0; e.fv = 0; e.fvec = 0; e.e0 = 0;
    for (int k = 0; k < nv; k++) begin
      if (((tbl >> k) & 1) != ((expv >> k) & 1)) begin
        if (e.errs == 0) begin e.fv = 1; e.fvec = k; end
        e.errs++;
      end
    end
    return e;
  endfunction

  // Monitors: vector stepping while busy, result and latency on every done rising edge.
  logic dq_a = 1'b0, dq_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_a) chk("vec_a", int'(vec_a), ((cyc - e0a) / 4) % 4);
    if (done_a && !dq_a) begin
      if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
        e = qa.pop_front();
        chk("lat_a", cyc - e.e0, 16);
        chk("err_a", int'(err_a), e.errs);
        chk("pass_a", int'(pass_a), int'(e.errs == 0));
        chk("fv_a", int'(fv_a), e.fv);
        if (e.fv != 0) chk("fvec_a", int'(fvec_a), e.fvec);
        chk("vec_a_done", int'(vec_a), 0);
        chk("busy_a_done", int'(busy_a), 0);
      end
    end
    dq_a = done_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy_b) chk("vec_b", int'(vec_b), (cyc - e0b) % 8);
    if (done_b && !dq_b) begin
      if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        e = qb.pop_front();
        chk("lat_b", cyc - e.e0, 8);
        chk("err_b", int'(err_b), e.errs);
        chk("pass_b", int'(pass_b), int'(e.errs == 0));
        chk("fv_b", int'(fv_b), e.fv);
        if (e.fv != 0) chk("fvec_b", int'(fvec_b), e.fvec);
      end
    end
    dq_b = done_b;
  end

  task automatic go_a(input bit keep, input bit expect_done);
    exp_t e;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    e0a = cyc;
    e = model(int'(tbl_a), 'hE, 4);
    e.e0 = cyc;
    if (expect_done) qa.push_back(e);
    if (!keep) start_a = 1'b0;
  endtask

  task automatic go_b;
    exp_t e;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1;
    e0b = cyc;
    e = model(int'(tbl_b), 'h80, 8);
    e.e0 = cyc;
    qb.push_back(e);
    start_b = 1'b0;
  endtask

  task automatic wait_a;
    int n = 0;
    while (!done_a && n < 60) begin @(negedge clk); n++; end
    if (!done_a) chk("timeout_a", 0, 1);
    start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_b;
    int n = 0;
    while (!done_b && n < 60) begin @(negedge clk); n++; end
    if (!done_b) chk("timeout_b", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_outs", int'({vec_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a}), 0);
    chk("rst_b_outs", int'({vec_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b}), 0);
    @(negedge clk); rst = 1'b0;

    tbl_a = 4'b1110; go_a(0, 1); wait_a();   // OR: pass
    tbl_a = 4'b1000; go_a(0, 1); wait_a();   // AND: 2 errors, first at 01

    // Abort mid-sweep, reset sampled at E0+7.
    tbl_a = 4'b1110; go_a(0, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outs", int'({vec_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a}), 0);
    rst = 1'b0;
    go_a(0, 1); wait_a();

    // start held high throughout RUN.
    tbl_a = 4'b0110; go_a(1, 1); wait_a();

    // Failing sweep, then restart from DONE with an OR gate.
    tbl_a = 4'b0001; go_a(0, 1); wait_a();
    tbl_a = 4'b1110; go_a(0, 1);
    chk("restart_err_clr", int'(err_a), 0);
    chk("restart_fv_clr", int'(fv_a), 0);
    chk("restart_busy", int'(busy_a), 1);
    wait_a();

    for (int i = 0; i < 6; i++) begin
      tbl_a = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go_a(0, 1); wait_a();
    end

    tbl_b = 8'h80; go_b(); wait_b();         // 3-input AND: pass
    tbl_b = 8'hFF; go_b(); wait_b();         // stuck at 1: 7 errors at 000
    for (int i = 0; i < 6; i++) begin
      tbl_b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go_b(); wait_b();
    end

    repeat (3) @(negedge clk);
    chk("qa_pending", qa.size(), 0);
    chk("qb_pending", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
